// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Host-side bundle of the scan controller: value/load/enable in, display pins and pulses out.
interface ssd_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_done;
  logic        load_ack;

  modport master (
    output en, load, value, blank_lz,
    input  seg, an, digit_sel, frame_done, load_ack
  );

  modport slave (
    input  en, load, value, blank_lz,
    output seg, an, digit_sel, frame_done, load_ack
  );
endinterface

// File: rtl/SSD.sv
// Combinational hex to seven-segment decoder, segments {g..a}, active-low.
module SSD
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with guard blanking,
// frame-boundary double buffering and leading-zero suppression.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DRIVE_CYC = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic            clk,
  input  logic            rst,
  ssd_scan_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (DRIVE_CYC > GUARD_CYC) ? DRIVE_CYC : GUARD_CYC;
  localparam int PW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PW-1:0] DRIVE_LAST = PW'(DRIVE_CYC - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYC - 1);

  state_t          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [15:0]     shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic [15:0]     active_q, active_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic [1:0]      sel_q;
  logic            frame_done_q, frame_done_d;
  logic            load_ack_q, load_ack_d;
  logic            frame_end;
  logic            lz_blank;
  logic [3:0]      nibble;
  logic [6:0]      dec_seg;

  SSD u_ssd (
    .hex (nibble),
    .seg (dec_seg)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    phase_d      = phase_q;
    frame_done_d = 1'b0;
    frame_end    = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (bus.en) begin
          state_d = ST_GUARD;
          digit_d = 2'd0;
          phase_d = '0;
        end
      end
      ST_GUARD: begin
        if (phase_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_DRIVE: begin
        if (phase_q == DRIVE_LAST) begin
          state_d = ST_GUARD;
          phase_d = '0;
          if (digit_q == 2'd3) begin
            frame_done_d = 1'b1;
            frame_end    = 1'b1;
            digit_d      = 2'd0;
          end else begin
            digit_d = digit_q + 2'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (!bus.en) begin
      state_d      = ST_OFF;
      digit_d      = 2'd0;
      phase_d      = '0;
      frame_done_d = 1'b0;
      frame_end    = 1'b0;
    end
  end

  // A strobe landing in a commit cycle goes straight to the active buffer.
  always_comb begin
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    active_d   = active_q;
    load_ack_d = 1'b0;
    if (bus.load) begin
      shadow_d  = bus.value;
      pending_d = 1'b1;
    end
    if ((frame_end || state_q == ST_OFF) && (pending_q || bus.load)) begin
      active_d   = bus.load ? bus.value : shadow_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
  end

  // Outputs describe the state being entered, so they look at digit_d.
  always_comb begin
    nibble   = active_q[{digit_d, 2'b00} +: 4];
    lz_blank = bus.blank_lz && (digit_d != 2'd0) &&
               ((active_q >> {digit_d, 2'b00}) == 16'd0);
    seg_d    = SEG_BLANK;
    an_d     = AN_OFF;
    if (state_d == ST_DRIVE && !lz_blank) begin
      seg_d = dec_seg;
      an_d  = ~(4'b0001 << digit_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      digit_q      <= 2'd0;
      phase_q      <= '0;
      shadow_q     <= 16'd0;
      pending_q    <= 1'b0;
      active_q     <= 16'd0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      sel_q        <= 2'd0;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      phase_q      <= phase_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      sel_q        <= digit_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.load_ack   = load_ack_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DRIVE_CYC=4, GUARD_CYC=2 (24-cycle frame).
module tb_ssd_scan_ctrl;
  import ssd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl_if bus ();

  ssd_scan_ctrl #(
    .DRIVE_CYC (4),
    .GUARD_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " seg"}, 16'(bus.seg), 16'h7F);
    check({tag, " an"},  16'(bus.an), 16'hF);
    check({tag, " sel"}, 16'(bus.digit_sel), 16'd0);
    check({tag, " fd"},  16'(bus.frame_done), 16'd0);
    check({tag, " ack"}, 16'(bus.load_ack), 16'd0);
  endtask

  // One digit slot: two guard cycles then four drive cycles.
  // ld_at=1 strobes load on the edge entering guard 1, ld_at=2 on guard 2.
  task automatic slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                      input logic [1:0] sel_e, input logic fd_e, input logic ack_e,
                      input int ld_at, input logic [15:0] ld_val);
    if (ld_at == 1) begin
      bus.load  = 1'b1;
      bus.value = ld_val;
    end
    step();
    bus.load = 1'b0;
    check({tag, " g1 an"},  16'(bus.an), 16'hF);
    check({tag, " g1 seg"}, 16'(bus.seg), 16'h7F);
    check({tag, " g1 fd"},  16'(bus.frame_done), 16'(fd_e));
    check({tag, " g1 ack"}, 16'(bus.load_ack), 16'(ack_e));
    if (ld_at == 2) begin
      bus.load  = 1'b1;
      bus.value = ld_val;
    end
    step();
    bus.load = 1'b0;
    check({tag, " g2 an"},  16'(bus.an), 16'hF);
    check({tag, " g2 fd"},  16'(bus.frame_done), 16'd0);
    check({tag, " g2 ack"}, 16'(bus.load_ack), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check({tag, " drv an"},  16'(bus.an), 16'(an_e));
      check({tag, " drv seg"}, 16'(bus.seg), 16'(seg_e));
      check({tag, " drv sel"}, 16'(bus.digit_sel), 16'(sel_e));
      check({tag, " drv fd"},  16'(bus.frame_done), 16'd0);
      check({tag, " drv ack"}, 16'(bus.load_ack), 16'd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.blank_lz = 1'b0;

    // Reset and idle with scanning disabled
    step();
    step();
    check_reset("rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_reset("idle");
    end

    // Load in OFF, then one full frame of 12AF
    bus.load  = 1'b1;
    bus.value = 16'h12AF;
    step();
    bus.load = 1'b0;
    check("off ack", 16'(bus.load_ack), 16'd1);
    check("off an",  16'(bus.an), 16'hF);
    step();
    check("off ack end", 16'(bus.load_ack), 16'd0);
    bus.en = 1'b1;
    slot("f1d0", 4'hE, 7'h0E, 2'd0, 1'b0, 1'b0, 0, 16'h0);
    slot("f1d1", 4'hD, 7'h08, 2'd1, 1'b0, 1'b0, 0, 16'h0);
    slot("f1d2", 4'hB, 7'h24, 2'd2, 1'b0, 1'b0, 0, 16'h0);
    slot("f1d3", 4'h7, 7'h79, 2'd3, 1'b0, 1'b0, 0, 16'h0);

    // Tear-free update: load 0003 during digit 1, blanking on
    bus.blank_lz = 1'b1;
    slot("f2d0", 4'hE, 7'h0E, 2'd0, 1'b1, 1'b0, 0, 16'h0);
    slot("f2d1", 4'hD, 7'h08, 2'd1, 1'b0, 1'b0, 2, 16'h0003);
    slot("f2d2", 4'hB, 7'h24, 2'd2, 1'b0, 1'b0, 0, 16'h0);
    slot("f2d3", 4'h7, 7'h79, 2'd3, 1'b0, 1'b0, 0, 16'h0);
    slot("f3d0", 4'hE, 7'h30, 2'd0, 1'b1, 1'b1, 0, 16'h0);
    slot("f3d1", 4'hF, 7'h7F, 2'd1, 1'b0, 1'b0, 0, 16'h0);
    slot("f3d2", 4'hF, 7'h7F, 2'd2, 1'b0, 1'b0, 0, 16'h0);
    slot("f3d3", 4'hF, 7'h7F, 2'd3, 1'b0, 1'b0, 0, 16'h0);

    // Two loads in one frame: last one wins, one ack
    slot("f4d0", 4'hE, 7'h30, 2'd0, 1'b1, 1'b0, 2, 16'h1111);
    slot("f4d1", 4'hF, 7'h7F, 2'd1, 1'b0, 1'b0, 2, 16'h2222);
    slot("f4d2", 4'hF, 7'h7F, 2'd2, 1'b0, 1'b0, 0, 16'h0);
    slot("f4d3", 4'hF, 7'h7F, 2'd3, 1'b0, 1'b0, 0, 16'h0);
    slot("f5d0", 4'hE, 7'h24, 2'd0, 1'b1, 1'b1, 0, 16'h0);
    slot("f5d1", 4'hD, 7'h24, 2'd1, 1'b0, 1'b0, 0, 16'h0);
    slot("f5d2", 4'hB, 7'h24, 2'd2, 1'b0, 1'b0, 0, 16'h0);
    slot("f5d3", 4'h7, 7'h24, 2'd3, 1'b0, 1'b0, 0, 16'h0);

    // Load in the commit cycle bypasses straight to the display
    slot("f6d0", 4'hE, 7'h12, 2'd0, 1'b1, 1'b1, 1, 16'h5555);
    slot("f6d1", 4'hD, 7'h12, 2'd1, 1'b0, 1'b0, 0, 16'h0);
    slot("f6d2", 4'hB, 7'h12, 2'd2, 1'b0, 1'b0, 0, 16'h0);
    slot("f6d3", 4'h7, 7'h12, 2'd3, 1'b0, 1'b0, 0, 16'h0);
    slot("f7d0", 4'hE, 7'h12, 2'd0, 1'b1, 1'b0, 0, 16'h0);
    slot("f7d1", 4'hD, 7'h12, 2'd1, 1'b0, 1'b0, 0, 16'h0);

    // Disable during digit-2 drive, then re-enable
    step();
    step();
    step();
    check("d2 driving an", 16'(bus.an), 16'hB);
    bus.en = 1'b0;
    step();
    check("dis an",  16'(bus.an), 16'hF);
    check("dis seg", 16'(bus.seg), 16'h7F);
    check("dis sel", 16'(bus.digit_sel), 16'd0);
    bus.en = 1'b1;
    slot("re d0", 4'hE, 7'h12, 2'd0, 1'b0, 1'b0, 0, 16'h0);

    // Reset mid-drive with a pending value
    slot("re d1", 4'hD, 7'h12, 2'd1, 1'b0, 1'b0, 2, 16'h9999);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check_reset("mid rst");
    rst = 1'b0;
    slot("r d0", 4'hE, 7'h40, 2'd0, 1'b0, 1'b0, 0, 16'h0);
    slot("r d1", 4'hF, 7'h7F, 2'd1, 1'b0, 1'b0, 0, 16'h0);
    slot("r d2", 4'hF, 7'h7F, 2'd2, 1'b0, 1'b0, 0, 16'h0);
    slot("r d3", 4'hF, 7'h7F, 2'd3, 1'b0, 1'b0, 0, 16'h0);
    slot("r2 d0", 4'hE, 7'h40, 2'd0, 1'b1, 1'b0, 0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It shares a single hex-to-seven-segment decoder across four digits, stepping through them with a programmable drive time and a blanking guard interval between digits. Display updates are double-buffered: a new 16-bit value is committed only at a frame boundary, so no frame ever mixes old and new digits. It sits between the board's seven-segment pins and any block that produces a 16-bit hex value (counters, debug registers).

## Interface
- DRIVE_CYC, 50000: cycles each digit is driven (≥1); 1 ms at 50 MHz.
- GUARD_CYC, 500: cycles all anodes are off before each digit (≥1).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 blanks the display.
- load  in  1  single-cycle strobe; capture `value`.
- value  in  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- blank_lz  in  1  leading-zero blanking enable.
- seg  out  7  segments {g..a}, active-low.
- an  out  4  digit anodes, active-low, one-hot-low when driving.
- digit_sel  out  2  index of the current digit.
- frame_done  out  1  one-cycle pulse at the end of digit 3 drive.
- load_ack  out  1  one-cycle pulse when the pending value is committed.

## Operation
- Registers: `shadow[15:0]`, `pending`, `active[15:0]`, `digit[1:0]`, a phase counter, and a 2-bit FSM.
- FSM states:
  - OFF: an=4'hF, seg=7'h7F. When en=1, go to GUARD with digit=0.
  - GUARD: an=4'hF, seg=7'h7F for GUARD_CYC cycles, then go to DRIVE.
  - DRIVE: held for DRIVE_CYC cycles.
    - an[digit]=0; seg is the decode of active[4*digit+:4], or 7'h7F if the digit is blanked.
    - At the last cycle: if digit==3, pulse frame_done, commit, and wrap digit to 0; otherwise digit+1. Then go to GUARD.
- en=0 in any state: next state is OFF, digit is cleared to 0, and the phase counter is cleared. `pending` and `shadow` are retained.
- Load:
  - load=1 writes `shadow`=value and sets pending=1. Repeated loads overwrite `shadow`, so the last value wins.
- Commit (end of digit-3 drive, or any cycle in OFF while pending=1):
  - `active`=`shadow`, pending=0, load_ack pulses.
  - If load=1 in the commit cycle, `value` bypasses `shadow` into `active` directly, pending ends at 0, and load_ack pulses.
- Leading-zero blanking, when blank_lz=1:
  - Digit i (i=3..1) is blanked if nibbles 3 down to i of `active` are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps its time slot, but an stays 4'hF for that slot.
- Decode (active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).

## Timing
- Reset values:
  - seg=7'h7F, an=4'hF, digit_sel=0, frame_done=0, load_ack=0.
  - FSM=OFF, shadow=0, active=0, pending=0, phase counter=0.
- seg, an, digit_sel, frame_done, and load_ack are all registered. They take the values for a state on the same edge that the FSM enters that state.
- Frame period is 4·(GUARD_CYC+DRIVE_CYC) cycles. frame_done and the frame-end load_ack are asserted on the first GUARD cycle of digit 0.
- en 0→1: the first GUARD cycle is one cycle later. en 1→0: outputs are blank on the next edge.
- Load in OFF: load_ack is high one cycle after the load strobe.
- The phase counter width is $clog2 of max(DRIVE_CYC, GUARD_CYC).
- rst mid-frame: all registers take their reset values on that edge, including loss of the pending value.

## Structure
- Shared package `ssd_pkg`:
  - FSM state typedef (OFF/GUARD/DRIVE).
  - SEG_BLANK=7'h7F and AN_OFF=4'hF constants.
- One sub-module: the team's existing `SSD` combinational decoder (4-bit in, 7-bit active-low out), instantiated once. Its input is the nibble mux output.

## Test plan
All scenarios use DRIVE_CYC=4 and GUARD_CYC=2, giving a 24-cycle frame.
1. Reset: assert rst for 2 cycles → seg=7'h7F, an=4'hF, digit_sel=0, frame_done=0, load_ack=0; hold for 10 cycles with en=0 → no change.
2. Full frame: load 16'h12AF in OFF, then en=1 → load_ack one cycle after load; each digit gets 2 blank cycles, then:
   - digit 0: an=1110, seg=0E, for 4 cycles;
   - digit 1: an=1101, seg=08;
   - digit 2: an=1011, seg=24;
   - digit 3: an=0111, seg=79;
   - frame_done then pulses exactly every 24 cycles.
3. Tear-free update: load 16'h0003 during digit 1 of a frame showing 12AF, with blank_lz=1 → the rest of that frame still shows 12AF; load_ack coincides with frame_done; the next frame has an=4'hF for digits 3..1 and digit 0 shows an=1110, seg=30.
4. Load collisions:
   - two loads mid-frame (0x1111, then 0x2222) → only 2222 is displayed, with one load_ack;
   - load 0x5555 in the commit cycle → the next frame shows 5555 and pending=0.
5. Disable: drop en during digit-2 DRIVE → next cycle an=4'hF, seg=7'h7F, digit_sel=0. Re-enable → 2 GUARD cycles, then digit 0.
6. Reset mid-operation: rst during DRIVE with pending=1 → reset values; after release with en=1, the display shows 0000 and no load_ack occurs.
